// File: rtl/sram_write_cmd_sequencer_if.sv
// Bundle of segment input, DRAM line-request and collector-command channels
// for the SRAM write command sequencer.
interface sram_write_cmd_sequencer_if #(
    parameter int GBW   = 16,
    parameter int LBW   = 11,
    parameter int CSIZE = 8,
    parameter int VSIZE = 8
);
    localparam int CC_BW  = $clog2(CSIZE);
    localparam int CV_BW1 = $clog2(VSIZE + 1);

    // segment channel (from the DMA address generator)
    logic                    i_seg_rdy;
    logic                    o_seg_ack;
    logic                    i_seg_which;
    logic [1:0]              i_seg_type;
    logic [GBW-1:0]          i_seg_addr;
    logic [LBW:0]            i_seg_len;

    // DRAM line-request channel
    logic                    o_dramra_rdy;
    logic                    i_dramra_ack;
    logic [GBW-CC_BW-1:0]    o_dramra;

    // collector command channel
    logic                    o_cmd_rdy;
    logic                    i_cmd_ack;
    logic                    o_which;
    logic [1:0]              o_cmd_type;
    logic                    o_cmd_islast;
    logic [CC_BW-1:0]        o_cmd_addrofs;
    logic [CV_BW1-1:0]       o_cmd_len;

    modport slave (
        input  i_seg_rdy, i_seg_which, i_seg_type, i_seg_addr, i_seg_len,
        input  i_dramra_ack, i_cmd_ack,
        output o_seg_ack, o_dramra_rdy, o_dramra,
        output o_cmd_rdy, o_which, o_cmd_type, o_cmd_islast, o_cmd_addrofs, o_cmd_len
    );

    modport master (
        output i_seg_rdy, i_seg_which, i_seg_type, i_seg_addr, i_seg_len,
        output i_dramra_ack, i_cmd_ack,
        input  o_seg_ack, o_dramra_rdy, o_dramra,
        input  o_cmd_rdy, o_which, o_cmd_type, o_cmd_islast, o_cmd_addrofs, o_cmd_len
    );
endinterface

// File: rtl/sram_write_cmd_sequencer.sv
// Splits DMA segments (linear / broadcast / pad) into DRAM line requests and
// per-chunk write-collector commands. The two output channels run as
// independent engines so DRAM fetches may run ahead of command consumption.
module sram_write_cmd_sequencer #(
    parameter int GBW   = 16,
    parameter int LBW   = 11,
    parameter int CSIZE = 8,
    parameter int VSIZE = 8
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    sram_write_cmd_sequencer_if.slave   io_bus
);
    localparam int CC_BW  = $clog2(CSIZE);
    localparam int CV_BW1 = $clog2(VSIZE + 1);
    localparam int LW     = GBW - CC_BW;
    localparam int RW     = LBW + 1;
    localparam int OW     = CC_BW + 1;

    localparam logic [1:0]    SEG_LINEAR = 2'd0;
    localparam logic [1:0]    SEG_BCAST  = 2'd1;
    localparam logic [RW-1:0] VSIZE_R    = RW'(VSIZE);
    localparam logic [RW-1:0] CSIZE_R    = RW'(CSIZE);
    localparam logic [OW-1:0] CSIZE_O    = OW'(CSIZE);

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 r_state;
    state_t                 w_state_next;

    // command engine state: r_cur / r_rem describe what is left after the
    // chunk currently presented on the command channel
    logic                   r_cmd_rdy;
    logic                   r_which;
    logic [1:0]             r_type;
    logic [GBW-1:0]         r_cur;
    logic [RW-1:0]          r_rem;
    logic                   r_cmd_islast;
    logic [CC_BW-1:0]       r_cmd_addrofs;
    logic [CV_BW1-1:0]      r_cmd_len;

    // DRAM engine state
    logic                   r_dram_rdy;
    logic [LW-1:0]          r_line;
    logic [LW-1:0]          r_last_line;

    logic                   w_seg_take;
    logic                   w_load;
    logic                   w_cmd_fire;
    logic                   w_dram_fire;
    logic                   w_cmd_done;
    logic                   w_dram_done;
    logic [LW-1:0]          w_end_line;

    // chunk calculator signals
    logic [GBW-1:0]         w_src_cur;
    logic [RW-1:0]          w_src_rem;
    logic [1:0]             w_src_type;
    logic [CC_BW-1:0]       w_ofs;
    logic [RW-1:0]          w_room;
    logic [RW-1:0]          w_len;
    logic [RW-1:0]          w_rem_after;
    logic                   w_line_end;
    logic                   w_islast;
    logic [CC_BW-1:0]       w_addrofs;
    logic [GBW-1:0]         w_cur_next;

    assign w_seg_take  = i_rst && (r_state == IDLE) && io_bus.i_seg_rdy;
    assign w_load      = w_seg_take && (io_bus.i_seg_len != '0);
    assign w_cmd_fire  = r_cmd_rdy && io_bus.i_cmd_ack;
    assign w_dram_fire = r_dram_rdy && io_bus.i_dramra_ack;
    assign w_cmd_done  = !r_cmd_rdy || (w_cmd_fire && (r_rem == '0));
    assign w_dram_done = !r_dram_rdy || (w_dram_fire && (r_line == r_last_line));
    assign w_end_line  = LW'((io_bus.i_seg_addr + GBW'(io_bus.i_seg_len) - GBW'(1)) >> CC_BW);

    assign io_bus.o_seg_ack     = w_seg_take;
    assign io_bus.o_dramra_rdy  = r_dram_rdy;
    assign io_bus.o_dramra      = r_line;
    assign io_bus.o_cmd_rdy     = r_cmd_rdy;
    assign io_bus.o_which       = r_which;
    assign io_bus.o_cmd_type    = r_type;
    assign io_bus.o_cmd_islast  = r_cmd_islast;
    assign io_bus.o_cmd_addrofs = r_cmd_addrofs;
    assign io_bus.o_cmd_len     = r_cmd_len;

    // state register
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) r_state <= IDLE;
        else        r_state <= w_state_next;
    end

    // next state: leave RUN once both engines have drained
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_load) w_state_next = RUN;
            RUN:     if (w_cmd_done && w_dram_done) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // next chunk: from the incoming segment in IDLE, from the engine state in RUN
    always_comb begin
        w_src_cur  = r_cur;
        w_src_rem  = r_rem;
        w_src_type = r_type;
        if (r_state == IDLE) begin
            w_src_cur  = io_bus.i_seg_addr;
            w_src_rem  = io_bus.i_seg_len;
            w_src_type = io_bus.i_seg_type;
        end
        w_ofs  = w_src_cur[CC_BW-1:0];
        w_room = CSIZE_R - RW'(w_ofs);
        w_len  = (w_src_rem < VSIZE_R) ? w_src_rem : VSIZE_R;
        if ((w_src_type == SEG_LINEAR) && (w_room < w_len)) w_len = w_room;
        w_rem_after = w_src_rem - w_len;
        w_line_end  = (({1'b0, w_ofs} + OW'(w_len)) == CSIZE_O);
        w_islast    = 1'b0;
        w_addrofs   = '0;
        w_cur_next  = w_src_cur;
        case (w_src_type)
            SEG_LINEAR: begin
                w_islast   = w_line_end || (w_rem_after == '0);
                w_addrofs  = w_ofs;
                w_cur_next = w_src_cur + GBW'(w_len);
            end
            SEG_BCAST: begin
                // address never advances, so the offset stays fixed
                w_islast  = (w_rem_after == '0);
                w_addrofs = w_ofs;
            end
            default: ;  // pad: offset 0, never consumes DRAM data
        endcase
    end

    // command engine: present a chunk, replace it on ack until nothing remains
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_cmd_rdy     <= 1'b0;
            r_which       <= 1'b0;
            r_type        <= '0;
            r_cur         <= '0;
            r_rem         <= '0;
            r_cmd_islast  <= 1'b0;
            r_cmd_addrofs <= '0;
            r_cmd_len     <= '0;
        end else if (w_load || (w_cmd_fire && (r_rem != '0))) begin
            if (w_load) begin
                r_which <= io_bus.i_seg_which;
                r_type  <= io_bus.i_seg_type;
            end
            r_cmd_rdy     <= 1'b1;
            r_cur         <= w_cur_next;
            r_rem         <= w_rem_after;
            r_cmd_islast  <= w_islast;
            r_cmd_addrofs <= w_addrofs;
            r_cmd_len     <= CV_BW1'(w_len);
        end else if (w_cmd_fire) begin
            r_cmd_rdy <= 1'b0;
        end
    end

    // DRAM engine: walk line addresses from first to last, one per ack
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_dram_rdy  <= 1'b0;
            r_line      <= '0;
            r_last_line <= '0;
        end else if (w_load && ((io_bus.i_seg_type == SEG_LINEAR) || (io_bus.i_seg_type == SEG_BCAST))) begin
            r_dram_rdy  <= 1'b1;
            r_line      <= io_bus.i_seg_addr[GBW-1:CC_BW];
            r_last_line <= (io_bus.i_seg_type == SEG_LINEAR) ? w_end_line
                                                              : io_bus.i_seg_addr[GBW-1:CC_BW];
        end else if (w_dram_fire) begin
            if (r_line == r_last_line) r_dram_rdy <= 1'b0;
            else                       r_line     <= r_line + LW'(1);
        end
    end
endmodule

// File: tb/tb_sram_write_cmd_sequencer.sv
// Scoreboard bench for sram_write_cmd_sequencer (CSIZE = VSIZE = 8).
module tb_sram_write_cmd_sequencer;
    localparam int GBW    = 12;
    localparam int LBW    = 7;
    localparam int CSIZE  = 8;
    localparam int VSIZE  = 8;
    localparam int CC_BW  = $clog2(CSIZE);
    localparam int CV_BW1 = $clog2(VSIZE + 1);

    logic i_clk = 1'b0;
    logic i_rst = 1'b0;
    always #5 i_clk = ~i_clk;

    sram_write_cmd_sequencer_if #(.GBW(GBW), .LBW(LBW), .CSIZE(CSIZE), .VSIZE(VSIZE)) bus_if ();

    sram_write_cmd_sequencer #(.GBW(GBW), .LBW(LBW), .CSIZE(CSIZE), .VSIZE(VSIZE)) dut (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .io_bus (bus_if)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cmd_mode  = 0;   // 0 always ack, 1 hold ack low 5 cycles, 2 random
    int dram_mode = 0;   // 0 always ack, 1 random

    logic [31:0] exp_cmd_q[$];
    logic [31:0] exp_line_q[$];

    logic        prev_cmd_pend  = 1'b0;
    logic [31:0] prev_cmd_val   = '0;
    logic        prev_dram_pend = 1'b0;
    logic [31:0] prev_dram_val  = '0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pack_cmd(input logic w, input logic [1:0] t, input logic l,
                                             input logic [CC_BW-1:0] o, input logic [CV_BW1-1:0] n);
        return 32'({w, t, l, o, n});
    endfunction

    function automatic logic [31:0] cur_cmd();
        return pack_cmd(bus_if.o_which, bus_if.o_cmd_type, bus_if.o_cmd_islast,
                        bus_if.o_cmd_addrofs, bus_if.o_cmd_len);
    endfunction

    // reference model: linear segments are walked word by word
    task automatic push_expect(input int which, input int typ, input int addr, input int len);
        int prev_line, cnt, ofs, a, ln, rem, n;
        logic eol, fin;
        prev_line = -1;
        cnt = 0;
        ofs = 0;
        if (len == 0) return;
        if (typ == 0) begin
            for (int i = 0; i < len; i++) begin
                a  = (addr + i) % (1 << GBW);
                ln = a / CSIZE;
                if (ln != prev_line) exp_line_q.push_back(32'(ln));
                prev_line = ln;
                if (cnt == 0) ofs = a % CSIZE;
                cnt++;
                eol = ((a % CSIZE) == CSIZE - 1);
                fin = (i == len - 1);
                if (cnt == VSIZE || eol || fin) begin
                    exp_cmd_q.push_back(pack_cmd(1'(which), 2'(typ), eol || fin, CC_BW'(ofs), CV_BW1'(cnt)));
                    cnt = 0;
                end
            end
        end else begin
            if (typ == 1) exp_line_q.push_back(32'(addr / CSIZE));
            rem = len;
            while (rem > 0) begin
                n = (rem < VSIZE) ? rem : VSIZE;
                rem -= n;
                exp_cmd_q.push_back(pack_cmd(1'(which), 2'(typ), (typ == 1) && (rem == 0),
                                             CC_BW'((typ == 1) ? (addr % CSIZE) : 0), CV_BW1'(n)));
            end
        end
    endtask

    // ack drivers
    initial begin
        int bp_cnt;
        bp_cnt = 0;
        bus_if.i_cmd_ack    = 1'b0;
        bus_if.i_dramra_ack = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            case (cmd_mode)
                0: begin bus_if.i_cmd_ack = 1'b1; bp_cnt = 0; end
                1: begin
                    if (bus_if.i_cmd_ack) begin
                        bus_if.i_cmd_ack = 1'b0;
                        bp_cnt = 0;
                    end else if (bus_if.o_cmd_rdy) begin
                        bp_cnt++;
                        if (bp_cnt >= 5) bus_if.i_cmd_ack = 1'b1;
                    end
                end
                default: bus_if.i_cmd_ack = 1'($urandom_range(0, 1));
            endcase
            bus_if.i_dramra_ack = (dram_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        end
    end

    // monitor: pops the scoreboard on every handshake, checks channel stability
    always @(negedge i_clk) begin
        if (!i_rst) begin
            prev_cmd_pend  = 1'b0;
            prev_dram_pend = 1'b0;
        end else begin
            if (prev_cmd_pend) begin
                check_eq("cmd_rdy_hold", 32'(bus_if.o_cmd_rdy), 32'd1);
                check_eq("cmd_stable", cur_cmd(), prev_cmd_val);
            end
            if (prev_dram_pend) begin
                check_eq("dram_rdy_hold", 32'(bus_if.o_dramra_rdy), 32'd1);
                check_eq("dram_stable", 32'(bus_if.o_dramra), prev_dram_val);
            end
            if (bus_if.o_cmd_rdy && bus_if.i_cmd_ack) begin
                $display("[TB] cmd which=%0d type=%0d ofs=%0d len=%0d last=%0d", bus_if.o_which,
                         bus_if.o_cmd_type, bus_if.o_cmd_addrofs, bus_if.o_cmd_len, bus_if.o_cmd_islast);
                if (exp_cmd_q.size() == 0) check_eq("cmd_unexpected", 32'd1, 32'd0);
                else check_eq("cmd", cur_cmd(), exp_cmd_q.pop_front());
            end
            if (bus_if.o_dramra_rdy && bus_if.i_dramra_ack) begin
                $display("[TB] dram line=%0d", bus_if.o_dramra);
                if (exp_line_q.size() == 0) check_eq("dram_unexpected", 32'd1, 32'd0);
                else check_eq("dram_line", 32'(bus_if.o_dramra), exp_line_q.pop_front());
            end
            prev_cmd_pend  = bus_if.o_cmd_rdy && !bus_if.i_cmd_ack;
            prev_cmd_val   = cur_cmd();
            prev_dram_pend = bus_if.o_dramra_rdy && !bus_if.i_dramra_ack;
            prev_dram_val  = 32'(bus_if.o_dramra);
        end
    end

    task automatic send_seg(input int which, input int typ, input int addr, input int len);
        logic ok;
        ok = 1'b0;
        @(posedge i_clk);
        #1;
        bus_if.i_seg_which = 1'(which);
        bus_if.i_seg_type  = 2'(typ);
        bus_if.i_seg_addr  = GBW'(addr);
        bus_if.i_seg_len   = (LBW + 1)'(len);
        bus_if.i_seg_rdy   = 1'b1;
        for (int k = 0; k < 500; k++) begin
            @(negedge i_clk);
            if (bus_if.o_seg_ack) begin ok = 1'b1; break; end
        end
        check_eq("seg_ack_timeout", 32'(ok), 32'd1);
        if (ok) begin
            // the previous segment must be fully drained before the next ack
            check_eq("seg_ack_idle", 32'(exp_cmd_q.size() + exp_line_q.size()), 32'd0);
            push_expect(which, typ, addr, len);
            $display("[TB] seg which=%0d type=%0d addr=%0d len=%0d", which, typ, addr, len);
        end
        @(posedge i_clk);
        #1;
        bus_if.i_seg_rdy = 1'b0;
    endtask

    task automatic wait_idle();
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 2000; k++) begin
            @(negedge i_clk);
            #1;
            if (exp_cmd_q.size() == 0 && exp_line_q.size() == 0 &&
                !bus_if.o_cmd_rdy && !bus_if.o_dramra_rdy) begin ok = 1'b1; break; end
        end
        check_eq("idle_timeout", 32'(ok), 32'd1);
    endtask

    initial begin
        logic found;
        bus_if.i_seg_rdy   = 1'b0;
        bus_if.i_seg_which = 1'b0;
        bus_if.i_seg_type  = '0;
        bus_if.i_seg_addr  = '0;
        bus_if.i_seg_len   = '0;

        // reset state, with a segment offered during reset
        repeat (2) @(posedge i_clk);
        #1;
        bus_if.i_seg_rdy = 1'b1;
        #1;
        check_eq("rst_seg_ack", 32'(bus_if.o_seg_ack), 32'd0);
        check_eq("rst_cmd_rdy", 32'(bus_if.o_cmd_rdy), 32'd0);
        check_eq("rst_dram_rdy", 32'(bus_if.o_dramra_rdy), 32'd0);
        check_eq("rst_fields", cur_cmd() | 32'(bus_if.o_dramra), 32'd0);
        bus_if.i_seg_rdy = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;

        // linear, broadcast, pad with no backpressure
        send_seg(0, 0, 13, 12);
        wait_idle();
        send_seg(1, 1, 21, 10);
        wait_idle();
        send_seg(0, 2, 37, 9);
        wait_idle();

        // command backpressure; DRAM runs ahead, next segment waits
        cmd_mode = 1;
        send_seg(0, 0, 13, 12);
        repeat (3) @(negedge i_clk);
        #1;
        check_eq("bp_dram_ahead", 32'(exp_line_q.size()), 32'd0);
        check_eq("bp_cmd_pending", 32'(exp_cmd_q.size()), 32'd3);
        send_seg(1, 1, 21, 10);
        wait_idle();
        cmd_mode = 0;

        // edge segments
        send_seg(0, 0, 100, 0);
        repeat (4) @(negedge i_clk);
        check_eq("len0_cmd_rdy", 32'(bus_if.o_cmd_rdy), 32'd0);
        check_eq("len0_dram_rdy", 32'(bus_if.o_dramra_rdy), 32'd0);
        send_seg(0, 0, 7, 2);
        send_seg(1, 0, (1 << GBW) - 1, 2);
        wait_idle();

        // asynchronous reset while the second command is pending
        cmd_mode = 1;
        send_seg(0, 0, 13, 12);
        found = 1'b0;
        for (int k = 0; k < 100; k++) begin
            @(posedge i_clk);
            #2;
            if (exp_cmd_q.size() == 2 && bus_if.o_cmd_rdy) begin found = 1'b1; break; end
        end
        check_eq("cmd2_pending_timeout", 32'(found), 32'd1);
        #1;
        i_rst = 1'b0;
        #1;
        check_eq("arst_cmd_rdy", 32'(bus_if.o_cmd_rdy), 32'd0);
        check_eq("arst_dram_rdy", 32'(bus_if.o_dramra_rdy), 32'd0);
        check_eq("arst_fields", cur_cmd() | 32'(bus_if.o_dramra), 32'd0);
        exp_cmd_q.delete();
        exp_line_q.delete();
        cmd_mode = 0;
        repeat (2) @(posedge i_clk);
        @(negedge i_clk);
        i_rst = 1'b1;
        send_seg(1, 0, 7, 2);
        wait_idle();

        // random segments with random acks on both channels
        cmd_mode  = 2;
        dram_mode = 1;
        for (int s = 0; s < 25; s++) begin
            send_seg(int'($urandom_range(0, 1)), int'($urandom_range(0, 2)),
                     int'($urandom_range(0, (1 << GBW) - 1)), int'($urandom_range(0, 40)));
        end
        wait_idle();
        cmd_mode  = 0;
        dram_mode = 0;

        repeat (3) @(negedge i_clk);
        check_eq("end_queues", 32'(exp_cmd_q.size() + exp_line_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_write_cmd_sequencer.md
# sram_write_cmd_sequencer

Splits DMA segments (linear, broadcast, pad) into DRAM line-read requests and per-chunk collector commands for the SRAM write collector in the TileAccumUnit DMA pipeline. It sits between the DMA address generator and the write collector, and sequences the collector's `cmd` port. DRAM requests and commands are issued on independent rdy/ack channels, so DRAM fetches can run ahead of command consumption.

## Interface
- `GBW`, `TauCfg::GLOBAL_ADDR_BW`, global word-address width
- `LBW`, `TauCfg::MAX_LOCAL_ADDR_BW`, segment length width minus 1
- `CSIZE`, `TauCfg::CACHE_SIZE`, words per DRAM line (power of 2); `CC_BW=$clog2(CSIZE)`
- `VSIZE`, `TauCfg::VSIZE`, words per SRAM vector; `CV_BW1=$clog2(VSIZE+1)`

Ports:
- `i_clk`  in  1  clock
- `i_rst`  in  1  reset, asynchronous, active-low
- `i_seg_rdy` / `o_seg_ack`  in / out  1  segment handshake
- `i_seg_which`  in  1  target SRAM bank
- `i_seg_type`  in  2  0 = linear, 1 = broadcast, 2 = pad
- `i_seg_addr`  in  GBW  start word address (ignored for pad)
- `i_seg_len`  in  LBW+1  word count
- `o_dramra_rdy` / `i_dramra_ack`  out / in  1  DRAM line request
- `o_dramra`  out  GBW-CC_BW  line address
- `o_cmd_rdy` / `i_cmd_ack`  out / in  1  collector command
- `o_which`  out  1  bank
- `o_cmd_type`  out  2  segment type
- `o_cmd_islast`  out  1  last command consuming the current DRAM line
- `o_cmd_addrofs`  out  CC_BW  word offset in the line
- `o_cmd_len`  out  CV_BW1  words in this chunk, 1..VSIZE

## Operation
- FSM states: IDLE, RUN. Reset enters IDLE. On reset, all outputs are 0, including both rdy signals.
- IDLE:
  - When `i_seg_rdy`, assert `o_seg_ack` combinationally and latch the segment.
  - If `i_seg_len`=0, stay in IDLE and issue nothing.
  - Otherwise go to RUN.
- RUN holds two independent engines.
  - DRAM engine:
    - Linear: issues lines `addr>>CC_BW` through `(addr+len-1)>>CC_BW`, ascending.
    - Broadcast: issues one line, `addr>>CC_BW`.
    - Pad: issues nothing.
    - Each line is presented with `o_dramra_rdy`=1 until acked; the next line appears the following cycle.
  - Command engine, tracking remaining word count `rem` and current address `cur`:
    - Linear: `len = min(VSIZE, CSIZE - cur[CC_BW-1:0], rem)`, `addrofs = cur[CC_BW-1:0]`. `islast` = 1 when the chunk reaches the line end or `rem` reaches 0. `cur` advances by `len`.
    - Broadcast: `len = min(VSIZE, rem)`. `addrofs = addr[CC_BW-1:0]`, constant. `islast` = 1 only on the final chunk.
    - Pad: `len = min(VSIZE, rem)`, `addrofs` = 0, `islast` = 0 always. This is required because the collector needs DRAM data whenever `islast` is set.
- RUN exits to IDLE in the cycle where the last outstanding handshake of both engines completes. The next segment is acked from IDLE, so there is one bubble cycle between segments.
- Arithmetic:
  - `rem` is LBW+1 bits and is decremented by `len` on each `i_cmd_ack`.
  - Line end is detected as `cur[CC_BW-1:0] + len == CSIZE`, computed in CC_BW+1 bits.
  - `cur` wraps modulo 2^GBW. Line addresses wrap modulo 2^(GBW-CC_BW).

## Timing
- Command and DRAM outputs are registered. The first `o_cmd_rdy` and `o_dramra_rdy` appear the cycle after `o_seg_ack`.
- With no backpressure, throughput is 1 command per cycle and 1 line request per cycle.
- While its rdy is high and unacked, every output field on that channel stays stable.
- `o_seg_ack` is never asserted in RUN.
- The DRAM engine finishing does not stall the command engine, and vice versa.
- When both channels ack in the same cycle, both engines advance.
- Asynchronous reset mid-RUN:
  - Both rdy signals drop to 0 immediately.
  - The FSM returns to IDLE and the partial segment is discarded.

## Test plan
Bench configuration: CSIZE=VSIZE=8.
- Linear, addr=13, len=12, no backpressure:
  - DRAM lines 1, 2, 3.
  - Cmds (ofs,len,islast): (5,3,1), (0,8,1), (0,1,1).
  - Returns to IDLE after the 3rd cmd ack.
- Broadcast, addr=21, len=10:
  - One DRAM line, 2.
  - Cmds (5,8,0), (5,2,1), type=1.
- Pad, len=9:
  - No `o_dramra_rdy`.
  - Cmds (0,8,0), (0,1,0), type=2.
- Backpressure: `i_cmd_ack` low for 5 cycles on each cmd, `i_dramra_ack` always high (linear case above).
  - All 3 DRAM lines issue in the first 3 cycles.
  - Cmd fields stay stable while unacked.
  - `seg` is not acked again until the last cmd is acked.
- Edge segments:
  - len=0 is acked and produces no output.
  - Linear addr=7, len=2 gives lines 0 and 1, cmds (7,1,1), (0,1,1).
  - Linear addr=2^GBW−1, len=2 wraps to line 0.
- Assert `i_rst` while cmd 2 of the linear case is pending:
  - Outputs go to 0 immediately.
  - After release, a new segment is accepted normally from IDLE.
